// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S transmitter: format codes and
// the bit-counter width derived from the slot width.
package i2s_pkg;

  localparam logic I2S_MODE_PHILIPS = 1'b1;
  localparam logic I2S_MODE_LJ      = 1'b0;

  // The counter spans both slots of a frame: 0 .. 2*slot_w-1.
  function automatic int i2s_cnt_w(input int slot_w);
    return $clog2(2 * slot_w);
  endfunction

endpackage

// File: rtl/i2s_clk_en_gen.sv
// Divides the system clock into a registered square-wave level plus
// single-cycle rise/fall enables that coincide with the edge of the level.
module i2s_clk_en_gen
  import i2s_pkg::*;
#(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_clk,
  output logic o_rise,
  output logic o_fall
);

  localparam int            CW      = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(HALF - 1);

  logic [CW-1:0] r_cnt;
  logic          r_lvl;
  logic          w_tick;

  assign w_tick = (r_cnt == CNT_TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_lvl <= 1'b0;
    end else if (w_tick) begin
      r_cnt <= '0;
      r_lvl <= ~r_lvl;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Enables fire in the cycle whose closing edge flips the level.
  assign o_clk  = r_lvl;
  assign o_rise = w_tick & ~r_lvl;
  assign o_fall = w_tick &  r_lvl;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Stereo I2S / left-justified serialiser with a one-entry holding register.
// Define I2S_TX_UNDERRUN_ZERO_EN to mute underrun frames instead of repeating.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int SLOT_W    = 16,
  parameter int MCLK_HALF = 2,
  parameter int SCLK_HALF = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i2s_mode,
  input  logic [DATA_W-1:0] l_data,
  input  logic [DATA_W-1:0] r_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mclk,
  output logic              sclk,
  output logic              lrclk,
  output logic              sdin,
  output logic              underrun
);

  localparam int               FW       = 2 * SLOT_W;
  localparam int               CNT_W    = i2s_cnt_w(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FW - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(SLOT_W);

  logic w_mclk_rise, w_mclk_fall, w_sclk_rise, w_sclk_fall;
  logic w_unused_en;

  i2s_clk_en_gen #(.HALF(MCLK_HALF)) u_mclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_clk  (mclk),
    .o_rise (w_mclk_rise),
    .o_fall (w_mclk_fall)
  );

  i2s_clk_en_gen #(.HALF(SCLK_HALF)) u_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_clk  (sclk),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  assign w_unused_en = w_mclk_rise ^ w_mclk_fall ^ w_sclk_rise;

  logic                r_hold_full;
  logic [2*DATA_W-1:0] r_hold;
  logic [FW-1:0]       r_shift;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_started;
  logic                r_dly;
  logic                r_mode;
  logic                r_lr;
  logic                r_underrun;

  logic                w_accept;
  logic                w_bnd;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [SLOT_W-1:0]   w_l_pad, w_r_pad;
  logic [FW-1:0]       w_load, w_rot, w_refill;

  assign s_ready  = !r_hold_full;
  assign w_accept = s_valid && !r_hold_full;

  // The first SCLK fall after reset opens a frame even though bit_cnt is 0.
  assign w_bnd      = w_sclk_fall && (!r_started || (r_cnt == CNT_LAST));
  assign w_cnt_next = w_bnd ? '0 : r_cnt + 1'b1;

  assign w_l_pad = SLOT_W'(r_hold[2*DATA_W-1 -: DATA_W]) << (SLOT_W - DATA_W);
  assign w_r_pad = SLOT_W'(r_hold[DATA_W-1:0]) << (SLOT_W - DATA_W);
  assign w_load  = {w_l_pad, w_r_pad};

  // Rotating keeps the frame intact: after a full frame it is back in place.
  assign w_rot = {r_shift[FW-2:0], r_shift[FW-1]};

`ifdef I2S_TX_UNDERRUN_ZERO_EN
  assign w_refill = '0;
`else
  assign w_refill = w_rot;
`endif

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold <= {l_data, r_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_started   <= 1'b0;
      r_dly       <= 1'b0;
      r_mode      <= I2S_MODE_LJ;
      r_lr        <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= w_bnd && !r_hold_full;
      if (w_bnd && r_hold_full) begin
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold_full <= 1'b1;
      end
      if (w_sclk_fall) begin
        r_started <= 1'b1;
        r_cnt     <= w_cnt_next;
        r_lr      <= (w_cnt_next >= CNT_HALF);
        r_dly     <= r_shift[FW-1];
        if (w_bnd) begin
          r_mode  <= i2s_mode;
          r_shift <= r_hold_full ? w_load : w_refill;
        end else begin
          r_shift <= w_rot;
        end
      end
    end
  end

  assign lrclk    = r_lr;
  assign underrun = r_underrun;
  assign sdin     = (r_mode == I2S_MODE_PHILIPS) ? r_dly : r_shift[FW-1];

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer: 16-bit slots on the main instance,
// 24-bit slots on a second instance for the padding scenario.
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i2s_mode = 1'b0;
  logic [15:0] l_data = '0;
  logic [15:0] r_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, mclk, sclk, lrclk, sdin, underrun;

  logic        p_mode = 1'b0;
  logic [15:0] p_l_data = '0;
  logic [15:0] p_r_data = '0;
  logic        p_valid = 1'b0;
  logic        p_ready, p_mclk, p_sclk, p_lrclk, p_sdin, p_underrun;

  int checks = 0;
  int errors = 0;
  int cyc;

  i2s_tx_serializer #(.DATA_W(16), .SLOT_W(16), .MCLK_HALF(1), .SCLK_HALF(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .i2s_mode(i2s_mode), .l_data(l_data), .r_data(r_data),
    .s_valid(s_valid), .s_ready(s_ready), .mclk(mclk), .sclk(sclk), .lrclk(lrclk),
    .sdin(sdin), .underrun(underrun)
  );

  i2s_tx_serializer #(.DATA_W(16), .SLOT_W(24), .MCLK_HALF(1), .SCLK_HALF(4)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .i2s_mode(p_mode), .l_data(p_l_data), .r_data(p_r_data),
    .s_valid(p_valid), .s_ready(p_ready), .mclk(p_mclk), .sclk(p_sclk), .lrclk(p_lrclk),
    .sdin(p_sdin), .underrun(p_underrun)
  );

  always #5 clk = ~clk;

  // Edges since reset release: edge n leaves cyc == n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] pair(input int i);
    logic [7:0] b;
    b = 8'(i);
    pair = {8'hC3, b, 8'h3C, ~b};
  endfunction

  task automatic goto(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      checks++;
      errors++;
      $display("FAIL goto cyc got %0d want %0d", cyc, n);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    s_valid = 1'b0; p_valid = 1'b0; i2s_mode = 1'b0;
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mclk, sclk, lrclk, sdin, underrun, s_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_outs got %b want 000001", {mclk, sclk, lrclk, sdin, underrun, s_ready});
    end
    checks++;
    if ({p_mclk, p_sclk, p_lrclk, p_sdin, p_underrun, p_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_outs24 got %b want 000001", {p_mclk, p_sclk, p_lrclk, p_sdin, p_underrun, p_ready});
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    goto(1);
    checks++;
    if (mclk !== 1'b1) begin errors++; $display("FAIL mclk_first got %b want 1", mclk); end
    goto(2);
    checks++;
    if (mclk !== 1'b0) begin errors++; $display("FAIL mclk_second got %b want 0", mclk); end
    goto(3);
    checks++;
    if (sclk !== 1'b0) begin errors++; $display("FAIL sclk_c3 got %b want 0", sclk); end
    goto(4);
    checks++;
    if (sclk !== 1'b1) begin errors++; $display("FAIL sclk_rise_c4 got %b want 1", sclk); end
    goto(7);
    checks++;
    if ({sclk, underrun} !== 2'b10) begin errors++; $display("FAIL sclk_ur_c7 got %b want 10", {sclk, underrun}); end
    goto(8);
    checks++;
    if ({sclk, underrun, lrclk} !== 3'b010) begin
      errors++; $display("FAIL first_fall_c8 sclk/ur/lr got %b want 010", {sclk, underrun, lrclk});
    end
    goto(9);
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL ur_pulse_c9 got %b want 0", underrun); end
  endtask

  task automatic test_lj();
    logic [31:0] ef;
    ef = {16'hA5F0, 16'h0F0F};
    i2s_mode = 1'b0; l_data = 16'hA5F0; r_data = 16'h0F0F; s_valid = 1'b1;
    do_reset();
    goto(1);
    s_valid = 1'b0;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL lj_ready_after_accept got %b want 0", s_ready); end
    goto(7);
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL lj_ready_c7 got %b want 0", s_ready); end
    goto(8);
    checks++;
    if ({s_ready, underrun} !== 2'b10) begin errors++; $display("FAIL lj_boundary ready/ur got %b want 10", {s_ready, underrun}); end
    for (int k = 0; k < 32; k++) begin
      goto(8 + 8 * k);
      checks++;
      if ({lrclk, sdin} !== {(k >= 16), ef[31-k]}) begin
        errors++;
        $display("FAIL lj_bit k=%0d lr/sdin got %b want %b", k, {lrclk, sdin}, {(k >= 16), ef[31-k]});
      end
    end
  endtask

  task automatic test_i2s();
    logic [31:0] ef;
    logic        exp;
    ef = {16'hA5F0, 16'h0F0F};
    i2s_mode = 1'b1; l_data = 16'hA5F0; r_data = 16'h0F0F; s_valid = 1'b1;
    do_reset();
    goto(1);
    s_valid = 1'b0;
    for (int k = 0; k < 32; k++) begin
      goto(8 + 8 * k);
      exp = (k == 0) ? 1'b0 : ef[32-k];
      checks++;
      if ({lrclk, sdin} !== {(k >= 16), exp}) begin
        errors++;
        $display("FAIL i2s_bit k=%0d lr/sdin got %b want %b", k, {lrclk, sdin}, {(k >= 16), exp});
      end
    end
    goto(264);
    checks++;
    if ({lrclk, sdin} !== 2'b01) begin
      errors++; $display("FAIL i2s_r_lsb_next_frame lr/sdin got %b want 01", {lrclk, sdin});
    end
    i2s_mode = 1'b0;
  endtask

  task automatic test_underrun();
    logic [31:0] ef;
    int n_ur, first_ur, last_ur, k;
`ifdef I2S_TX_UNDERRUN_ZERO_EN
    ef = 32'h0;
`else
    ef = {16'hA5F0, 16'h0F0F};
`endif
    n_ur = 0; first_ur = -1; last_ur = -1;
    i2s_mode = 1'b0; l_data = 16'hA5F0; r_data = 16'h0F0F; s_valid = 1'b1;
    do_reset();
    goto(1);
    s_valid = 1'b0;
    for (int c = 8; c <= 520; c++) begin
      goto(c);
      if (underrun === 1'b1) begin
        n_ur++;
        if (first_ur < 0) first_ur = c;
        last_ur = c;
      end
      if (c >= 264 && c < 520 && ((c - 264) % 8) == 0) begin
        k = (c - 264) / 8;
        checks++;
        if (sdin !== ef[31-k]) begin
          errors++; $display("FAIL ur_frame_bit k=%0d got %b want %b", k, sdin, ef[31-k]);
        end
      end
    end
    checks++;
    if (n_ur != 2) begin errors++; $display("FAIL ur_count got %0d want 2", n_ur); end
    checks++;
    if (first_ur != 264 || last_ur != 520) begin
      errors++; $display("FAIL ur_times got %0d/%0d want 264/520", first_ur, last_ur);
    end
  endtask

  task automatic test_padding();
    logic exp_b;
    p_mode = 1'b0; p_l_data = 16'hFFFF; p_r_data = 16'h0000; p_valid = 1'b1;
    s_valid = 1'b0;
    do_reset();
    goto(1);
    p_valid = 1'b0;
    for (int k = 0; k < 48; k++) begin
      goto(8 + 8 * k);
      checks++;
      if ({p_lrclk, p_sdin} !== {(k >= 24), (k < 16)}) begin
        errors++;
        $display("FAIL pad_bit k=%0d lr/sdin got %b want %b", k, {p_lrclk, p_sdin}, {(k >= 24), (k < 16)});
      end
    end
    goto(391);
    checks++;
    if (p_underrun !== 1'b0) begin errors++; $display("FAIL pad_ur_c391 got %b want 0", p_underrun); end
    goto(392);
`ifdef I2S_TX_UNDERRUN_ZERO_EN
    exp_b = 1'b0;
`else
    exp_b = 1'b1;
`endif
    checks++;
    if ({p_underrun, p_lrclk, p_sdin} !== {2'b10, exp_b}) begin
      errors++; $display("FAIL pad_frame_len ur/lr/sdin got %b want %b", {p_underrun, p_lrclk, p_sdin}, {2'b10, exp_b});
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ef;
    logic        pend;
    int idx, acc, acc_at, f, k;
    idx = 0; acc = 0; acc_at = -1;
    i2s_mode = 1'b0;
    {l_data, r_data} = pair(0);
    s_valid = 1'b1;
    do_reset();
    pend = s_valid && s_ready;
    for (int c = 1; c <= 837; c++) begin
      goto(c);
      if (pend) begin
        acc++;
        idx++;
        {l_data, r_data} = pair(idx);
      end
      if (c == 776) acc_at = acc;
      if (c >= 8 && ((c - 8) % 8) == 0) begin
        f = (c - 8) / 256;
        k = ((c - 8) % 256) / 8;
        ef = pair(f);
        checks++;
        if ({lrclk, sdin} !== {(k >= 16), ef[31-k]}) begin
          errors++;
          $display("FAIL b2b_bit f=%0d k=%0d lr/sdin got %b want %b", f, k, {lrclk, sdin}, {(k >= 16), ef[31-k]});
        end
      end
      pend = s_valid && s_ready;
    end
    checks++;
    if (acc_at != 4) begin errors++; $display("FAIL b2b_accepts got %0d want 4", acc_at); end
    checks++;
    if ({sclk, sdin} !== 2'b11) begin errors++; $display("FAIL b2b_pre_reset sclk/sdin got %b want 11", {sclk, sdin}); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mclk, sclk, lrclk, sdin, underrun, s_ready} !== 6'b000001) begin
      errors++; $display("FAIL midframe_reset got %b want 000001", {mclk, sclk, lrclk, sdin, underrun, s_ready});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    goto(1);
    s_valid = 1'b0;
    ef = pair(idx);
    for (int kk = 0; kk < 32; kk++) begin
      goto(8 + 8 * kk);
      checks++;
      if ({lrclk, sdin} !== {(kk >= 16), ef[31-kk]}) begin
        errors++;
        $display("FAIL restart_bit k=%0d lr/sdin got %b want %b", kk, {lrclk, sdin}, {(kk >= 16), ef[31-kk]});
      end
    end
  endtask

  initial begin
    test_reset();
    test_lj();
    test_i2s();
    test_underrun();
    test_padding();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
